drp_adc_responder: RTL

Synthesizable responder side of the XADC Dynamic Reconfiguration Port (DRP) protocol used by the ADC front end. It emulates the XADC auxiliary-channel-3 conversion engine:
- samples a 12-bit input on a fixed conversion period;
- publishes each result at DRP address 0x13 and pulses EOC;
- answers DRP reads and writes with a fixed-latency DRDY.

It stands in for the XADC primitive in board bring-up without analog input and in closed-loop benches, feeding the existing DRP reader and 7-segment path unchanged.

---
 rtl/drp_adc_pkg.sv | 18 +
 rtl/conv_timer.sv | 40 ++++
 rtl/drp_adc_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/drp_adc_pkg.sv
// Shared register map, data width and DRP handshake state type
// for the XADC auxiliary-channel responder.
package drp_adc_pkg;

  localparam int DRP_DW  = 16;
  localparam int NUM_CFG = 3;

  localparam logic [6:0] ADDR_RESULT = 7'h13;
  localparam logic [6:0] ADDR_CFG0   = 7'h40;
  localparam logic [6:0] ADDR_CFG1   = 7'h41;
  localparam logic [6:0] ADDR_CFG2   = 7'h42;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } drp_state_t;

endpackage

// File: rtl/conv_timer.sv
// Free-running conversion period counter: BUSY outside the two acquisition
// cycles, a one-cycle EOC at the last count, and the matching capture strobe.
module conv_timer #(
  parameter int CONV_CYCLES = 26
) (
  input  logic CLK100MHZ,
  input  logic rst_n,
  output logic busy,
  output logic eoc,
  output logic capture
);

  localparam int TW = $clog2(CONV_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(CONV_CYCLES - 1);

  logic [TW-1:0] t_reg, t_next;
  logic          busy_reg, eoc_reg;

  always_comb begin
    t_next = (t_reg == T_LAST) ? '0 : t_reg + TW'(1);
  end

  // Flags are decoded from the next count so they line up with t itself.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      t_reg    <= '0;
      busy_reg <= 1'b0;
      eoc_reg  <= 1'b0;
    end else begin
      t_reg    <= t_next;
      busy_reg <= (t_next >= TW'(2));
      eoc_reg  <= (t_next == T_LAST);
    end
  end

  assign busy    = busy_reg;
  assign eoc     = eoc_reg;
  assign capture = eoc_reg;

endmodule

// File: rtl/drp_adc_responder.sv
// DRP responder emulating the XADC aux-channel conversion engine: result and
// CFG registers, fixed-latency DRDY handshake, sticky protocol error flag.
module drp_adc_responder
  import drp_adc_pkg::*;
#(
  parameter int         CONV_CYCLES = 26,
  parameter int         RD_LATENCY  = 2,
  parameter logic [4:0] CHAN_ID     = ADDR_RESULT[4:0]
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [11:0]       sample_in,
  input  logic [6:0]        DADDR_IN,
  input  logic              DEN_IN,
  input  logic              DWE_IN,
  input  logic [DRP_DW-1:0] DI_IN,
  output logic [DRP_DW-1:0] DO_OUT,
  output logic              DRDY_OUT,
  output logic              BUSY_OUT,
  output logic              EOC_OUT,
  output logic [4:0]        CHANNEL_OUT,
  output logic              drp_err
);

  localparam logic [6:0] RESULT_ADDR = {2'b00, CHAN_ID};
  localparam logic [3:0] LAT_LOAD    = 4'(RD_LATENCY - 1);

  // Reset asserts immediately, releases two clocks later in this domain.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync_reg <= 2'b00;
    else             rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  logic capture;

  conv_timer #(.CONV_CYCLES(CONV_CYCLES)) u_conv_timer (
    .CLK100MHZ (CLK100MHZ),
    .rst_n     (rst_n),
    .busy      (BUSY_OUT),
    .eoc       (EOC_OUT),
    .capture   (capture)
  );

  drp_state_t                      state_reg, state_next;
  logic [3:0]                      cnt_reg, cnt_next;
  logic [DRP_DW-1:0]               cap_reg, cap_next, do_next, rd_data, result_reg;
  logic [NUM_CFG-1:0][DRP_DW-1:0]  cfg_rd;
  logic                            accept, wr_en, drdy_next, err_next;
  logic                            drdy_reg, err_reg;
  logic [DRP_DW-1:0]               do_reg;
  logic [4:0]                      chan_reg;

  assign accept = (state_reg == IDLE) && DEN_IN;
  assign wr_en  = accept && DWE_IN;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n)       result_reg <= '0;
    else if (capture) result_reg <= {sample_in, 4'b0000};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
      logic [DRP_DW-1:0] cfg_reg;
      always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) cfg_reg <= '0;
        else if (wr_en && (DADDR_IN == ADDR_CFG0 + 7'(gi))) cfg_reg <= DI_IN;
      end
      assign cfg_rd[gi] = cfg_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (DADDR_IN)
      RESULT_ADDR: rd_data = result_reg;
      ADDR_CFG0:   rd_data = cfg_rd[0];
      ADDR_CFG1:   rd_data = cfg_rd[1];
      ADDR_CFG2:   rd_data = cfg_rd[2];
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (DEN_IN) begin
        state_next = WAIT;
        cnt_next   = LAT_LOAD;
      end
      WAIT: if (cnt_reg == 4'd0) state_next = IDLE;
            else                 cnt_next   = cnt_reg - 4'd1;
      default: state_next = IDLE;
    endcase
  end

  // DRDY is registered, so it is raised on the edge that lands in WAIT at count 0.
  always_comb begin
    cap_next = cap_reg;
    if (accept) cap_next = DWE_IN ? '0 : rd_data;
    drdy_next = (state_next == WAIT) && (cnt_next == 4'd0);
    do_next   = drdy_next ? cap_next : '0;
    err_next  = err_reg | (DEN_IN && (state_reg == WAIT));
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg  <= '0;
      do_reg   <= '0;
      drdy_reg <= 1'b0;
      err_reg  <= 1'b0;
      chan_reg <= '0;
    end else begin
      cap_reg  <= cap_next;
      do_reg   <= do_next;
      drdy_reg <= drdy_next;
      err_reg  <= err_next;
      chan_reg <= CHAN_ID;
    end
  end

  assign DO_OUT      = do_reg;
  assign DRDY_OUT    = drdy_reg;
  assign drp_err     = err_reg;
  assign CHANNEL_OUT = chan_reg;

endmodule
